// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the three-requester register write arbiter:
// FSM encodings, requester count, default data width and the round-robin pick.
package reg_write_arbiter_pkg;

    localparam int NREQ          = 3;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // First requesting index scanning (owner+1), (owner+2), owner, all mod 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] owner);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = owner;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(owner) + k) % NREQ;
            if (!found && req[idx]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [2:0] one_hot3(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/enabled_reg.sv
// WIDTH-bit register loaded when enable is high, cleared by async active-high reset.
// One cycle from d to q; no backpressure, enable alone decides when it loads.
module enabled_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of three requesters a write into a shared register.
// Grant registered at the sampling edge, write lands one edge later; a winner keeps gnt until it drops req.
module reg_write_arbiter #(
    parameter int WIDTH = reg_write_arbiter_pkg::DEFAULT_WIDTH,
    parameter int NREQ  = reg_write_arbiter_pkg::NREQ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [2:0]       gnt,
    output logic             done,
    output logic [1:0]       owner,
    output logic [WIDTH-1:0] q,
    output logic             busy
);
    import reg_write_arbiter_pkg::*;

    state_t           state, state_nxt;
    logic [2:0]       gnt_nxt;
    logic             done_nxt;
    logic [1:0]       owner_nxt;
    logic [1:0]       win, win_nxt;
    logic             reg_en;
    logic [WIDTH-1:0] reg_d;

    // owner resets to 2 so the first arbitration after reset starts at requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 3'b000;
            done  <= 1'b0;
            owner <= 2'd2;
            win   <= 2'd0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            owner <= owner_nxt;
            win   <= win_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        done_nxt  = 1'b0;
        owner_nxt = owner;
        win_nxt   = win;
        reg_en    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    win_nxt   = rr_pick(req, owner);
                    gnt_nxt   = one_hot3(win_nxt);
                    state_nxt = GRANT;
                end else begin
                    gnt_nxt = 3'b000;
                end
            end
            GRANT: begin
                reg_en    = 1'b1;
                owner_nxt = win;
                done_nxt  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // owner already points at the winner here, so this tests the holder's own request.
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 3'b000;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 3'b000;
            end
        endcase
    end

    always_comb begin
        case (win)
            2'd0:    reg_d = d0;
            2'd1:    reg_d = d1;
            default: reg_d = d2;
        endcase
    end

    enabled_reg #(.WIDTH(WIDTH)) u_shared_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (reg_en),
        .d      (reg_d),
        .q      (q)
    );

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_reg_write_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] req = 3'b000;
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0;
    logic [2:0] gnt;
    logic       done;
    logic [1:0] owner;
    logic [3:0] q;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    reg_write_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .gnt   (gnt),
        .done  (done),
        .owner (owner),
        .q     (q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: phase 0 idle, 1 writing, 2 holding.
    int         m_phase, m_owner, m_win;
    logic [2:0] m_gnt;
    logic       m_done;
    logic [3:0] m_q;

    function automatic logic [3:0] dsel(input int i);
        if (i == 0) return d0;
        if (i == 1) return d1;
        return d2;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_gnt = 3'b000; m_done = 1'b0;
            m_owner = 2; m_win = 0; m_q = 4'd0;
        end else begin
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (req != 3'b000) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 1; k <= 3; k++) begin
                        if (!found && req[(m_owner + k) % 3]) begin
                            m_win = (m_owner + k) % 3;
                            found = 1'b1;
                        end
                    end
                    m_gnt = 3'b000;
                    m_gnt[m_win] = 1'b1;
                    m_phase = 1;
                end else begin
                    m_gnt = 3'b000;
                end
            end else if (m_phase == 1) begin
                m_q = dsel(m_win);
                m_owner = m_win;
                m_done = 1'b1;
                m_phase = 2;
            end else if (!req[m_owner]) begin
                m_phase = 0;
                m_gnt = 3'b000;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ({gnt, done, owner, q, busy} !== {m_gnt, m_done, 2'(m_owner), m_q, (m_phase != 0)}) begin
                errors++;
                $display("FAIL cycle_model t=%0t got gnt=%b done=%b owner=%0d q=%h busy=%b exp gnt=%b done=%b owner=%0d q=%h busy=%b",
                         $time, gnt, done, owner, q, busy, m_gnt, m_done, m_owner, m_q, (m_phase != 0));
            end
            checks++;
            if ($countones(gnt) > 1 || $isunknown(gnt)) begin
                errors++;
                $display("FAIL gnt_onehot t=%0t got %b exp zero or one-hot", $time, gnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({q, gnt, owner, busy, done} !== {4'd0, 3'b000, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got q=%h gnt=%b owner=%0d busy=%b done=%b exp 0 000 2 0 0", q, gnt, owner, busy, done);
        end
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({q, gnt, owner, busy} !== {4'd0, 3'b000, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle got q=%h gnt=%b owner=%0d busy=%b exp 0 000 2 0", q, gnt, owner, busy);
        end
    endtask

    task automatic test_single();
        req = 3'b010; d1 = 4'b0101;
        tick();
        checks++;
        if ({gnt, done, q, busy} !== {3'b010, 1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_grant got gnt=%b done=%b q=%h busy=%b exp 010 0 0 1", gnt, done, q, busy);
        end
        tick();
        checks++;
        if ({q, done, owner} !== {4'b0101, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL single_write got q=%b done=%b owner=%0d exp 0101 1 1", q, done, owner);
        end
        req = 3'b000;
        tick();
        checks++;
        if ({gnt, done, busy} !== {3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_release got gnt=%b done=%b busy=%b exp 000 0 0", gnt, done, busy);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_g;
        pulse_reset();
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            exp_g = 3'b000;
            exp_g[i % 3] = 1'b1;
            tick();
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL fair_grant%0d got %b exp %b", i, gnt, exp_g);
            end
            tick();
            checks++;
            if ({q, owner, done} !== {4'(i % 3 + 1), 2'(i % 3), 1'b1}) begin
                errors++;
                $display("FAIL fair_write%0d got q=%0d owner=%0d done=%b exp q=%0d owner=%0d done=1",
                         i, q, owner, done, i % 3 + 1, i % 3);
            end
            req[i % 3] = 1'b0;
            tick();
            checks++;
            if ({gnt, busy} !== {3'b000, 1'b0}) begin
                errors++;
                $display("FAIL fair_gap%0d got gnt=%b busy=%b exp 000 0", i, gnt, busy);
            end
            req = 3'b111;
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_hold_data();
        req = 3'b010; d1 = 4'b0110;
        tick();
        tick();
        d1 = 4'b1111;
        tick();
        tick();
        checks++;
        if ({q, gnt, busy} !== {4'b0110, 3'b010, 1'b1}) begin
            errors++;
            $display("FAIL hold_data got q=%b gnt=%b busy=%b exp 0110 010 1", q, gnt, busy);
        end
        req = 3'b000;
        tick();
        d1 = 4'b0011; d0 = 4'b1010;
        tick();
        checks++;
        if ({q, busy} !== {4'b0110, 1'b0}) begin
            errors++;
            $display("FAIL idle_data got q=%b busy=%b exp 0110 0", q, busy);
        end
    endtask

    task automatic test_reset_mid_grant();
        pulse_reset();
        req = 3'b001; d0 = 4'b1001;
        tick();
        checks++;
        if (gnt !== 3'b001) begin
            errors++;
            $display("FAIL mid_grant_setup got gnt=%b exp 001", gnt);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({q, gnt, busy, done} !== {4'd0, 3'b000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_grant_reset got q=%h gnt=%b busy=%b done=%b exp 0 000 0 0", q, gnt, busy, done);
        end
        tick();
        reset = 1'b0;
        req = 3'b000;
        tick();
        checks++;
        if ({q, owner} !== {4'd0, 2'd2}) begin
            errors++;
            $display("FAIL mid_grant_after got q=%h owner=%0d exp 0 2", q, owner);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            req = 3'($urandom_range(0, 7));
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_hold_data();
        test_reset_mid_grant();
        test_random();
        @(posedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
